// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux select through the enabled channels, holding each for dwell+1 cycles.
// Latency: first sel one cycle after start; backpressure: none, stop ends the scan after the current channel.
module mux_scan_sequencer #(
    parameter int NCH     = 4,
    parameter int DWELL_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               cont_i,
    input  logic               stop_i,
    input  logic [NCH-1:0]     ch_mask_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic [1:0]         sel_o,
    output logic               sel_valid_o,
    output logic               sample_stb_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    typedef enum logic {IDLE, DWELL} state_t;

    state_t             state_q;
    logic [1:0]         sel_q;
    logic               sel_valid_q, stb_q, busy_q, done_q, err_q;
    logic               cont_q, stop_pend_q;
    logic [NCH-1:0]     mask_q;
    logic [DWELL_W-1:0] dwell_q, cnt_q;

    logic [1:0] next_d, first_d;
    logic       wrap_d, end_d;

    // First enabled channel found searching circularly upward from cur+1.
    function automatic logic [1:0] next_ch(input logic [1:0] cur, input logic [NCH-1:0] mask);
        logic [1:0] res;
        logic [1:0] idx;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = cur + 2'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        next_d  = next_ch(sel_q, mask_q);
        first_d = next_ch(2'd3, ch_mask_i);
        wrap_d  = (next_d <= sel_q);
        end_d   = (wrap_d && !cont_q) || stop_pend_q || stop_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            stb_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            mask_q      <= '0;
            dwell_q     <= '0;
            cnt_q       <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    stop_pend_q <= 1'b0;
                    if (start_i) begin
                        if (ch_mask_i != '0) begin
                            cont_q      <= cont_i;
                            mask_q      <= ch_mask_i;
                            dwell_q     <= dwell_i;
                            cnt_q       <= dwell_i;
                            sel_q       <= first_d;
                            stb_q       <= (dwell_i == '0);
                            sel_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= DWELL;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                DWELL: begin
                    if (stop_i) stop_pend_q <= 1'b1;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DWELL_W'(1);
                        stb_q <= (cnt_q == DWELL_W'(1));
                    end else if (end_d) begin
                        state_q     <= IDLE;
                        sel_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        stb_q       <= 1'b0;
                        done_q      <= 1'b1;
                    end else begin
                        sel_q <= next_d;
                        cnt_q <= dwell_q;
                        stb_q <= (dwell_q == '0);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sel_o        = sel_q;
    assign sel_valid_o  = sel_valid_q;
    assign sample_stb_o = stb_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
